// File: rtl/pc_sequencer.sv
// pc_sequencer: fetches one instruction at a time, holds it for execution and
// then selects the next program counter.
// The next PC is chosen from three sources: a jump target, a branch target or
// the sequential pc+4. A jr to a misaligned address parks the sequencer in
// HALT with a sticky fault, and only a reset leaves HALT.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        branch,
   input  logic        zero,
   input  logic        jmp,
   input  logic        jr,
   input  logic [31:0] expand,
   input  logic [31:0] rs,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_add4,
   output logic        fault
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t             state;
   state_t             state_nxt;

   logic [31:0]        pc_r;
   logic [31:0]        instr_r;
   logic               fault_r;

   logic signed [31:0] offset_s;
   logic [31:0]        br_target;
   logic [31:0]        jmp_target;
   logic [31:0]        next_pc;
   logic               in_fetch;
   logic               take_ack;
   logic               advance;
   logic               jr_misaligned;

   // Sequential successor; the add wraps naturally at 2^32.
   assign pc_add4    = pc_r + 32'd4;

   // The branch offset counts words, so scale it to bytes while keeping its sign.
   assign offset_s   = $signed(expand) <<< 2;
   assign br_target  = pc_add4 + $unsigned(offset_s);

   // The jump target keeps the 256 MB region of the next instruction.
   assign jmp_target = {pc_add4[31:28], instr_r[25:0], 2'b00};

   // The fetch is active in FETCH and in WAIT. An ack in any other state is
   // ignored, so it never disturbs the held instruction.
   assign in_fetch      = (state == FETCH) || (state == WAIT);
   assign take_ack      = in_fetch && imem_ack;

   // The control inputs are honoured only when the instruction retires.
   assign advance       = (state == EXEC) && !stall;
   assign jr_misaligned = jr && (rs[1:0] != 2'b00);

   // Select the next-PC target: a register jump beats an absolute jump, and
   // either jump beats a taken branch.
   always_comb begin
      next_pc = pc_add4;
      if (jr) begin
         next_pc = rs;
      end else if (jmp) begin
         next_pc = jmp_target;
      end else if (branch && zero) begin
         next_pc = br_target;
      end
   end

   // State register; reset returns to FETCH asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. An ack seen in FETCH skips WAIT, which gives a
   // one-cycle fetch. A stall holds only EXEC, so an ack that arrives
   // together with a stall still completes the fetch.
   always_comb begin
      state_nxt = state;
      case (state)
         FETCH:   state_nxt = imem_ack ? EXEC : WAIT;
         WAIT:    state_nxt = imem_ack ? EXEC : WAIT;
         EXEC: begin
            if (!stall) begin
               state_nxt = jr_misaligned ? HALT : FETCH;
            end
         end
         HALT:    state_nxt = HALT;
         default: state_nxt = FETCH;
      endcase
   end

   // Output decode. The request is also gated by reset, because the reset
   // state is FETCH and the request must still drop as soon as reset rises.
   always_comb begin
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      case (state)
         FETCH,
         WAIT:    imem_req    = !reset;
         EXEC:    instr_valid = 1'b1;
         default: begin
            imem_req    = 1'b0;
            instr_valid = 1'b0;
         end
      endcase
   end

   // PC, instruction latch and sticky fault. A misaligned jr leaves the pc on
   // the faulting instruction so that the failing address can be inspected.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_r    <= RESET_PC;
         instr_r <= 32'h0000_0000;
         fault_r <= 1'b0;
      end else begin
         if (take_ack) begin
            instr_r <= imem_rdata;
         end
         if (advance) begin
            if (jr_misaligned) begin
               fault_r <= 1'b1;
            end else begin
               pc_r <= next_pc;
            end
         end
      end
   end

   assign imem_addr = pc_r;
   assign pc        = pc_r;
   assign instr     = instr_r;
   assign fault     = fault_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: reset behaviour, sequential flow,
// branch and jump selection, fetch wait with execute stall, fault/halt,
// address wrap and reset in the middle of a fetch.
module tb_pc_sequencer;

   logic        clk;
   logic        reset;
   logic        branch;
   logic        zero;
   logic        jmp;
   logic        jr;
   logic [31:0] expand;
   logic [31:0] rs;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_add4;
   logic        fault;

   int passed = 0;
   int total  = 0;

   pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .reset       (reset),
      .branch      (branch),
      .zero        (zero),
      .jmp         (jmp),
      .jr          (jr),
      .expand      (expand),
      .rs          (rs),
      .stall       (stall),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc          (pc),
      .pc_add4     (pc_add4),
      .fault       (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle; inputs are driven and outputs sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // From FETCH: answer the fetch immediately, landing in EXEC.
   task automatic fetch_to_exec(input logic [31:0] word);
      imem_ack   = 1'b1;
      imem_rdata = word;
      step();
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
   endtask

   // From FETCH: run one instruction that does jr to addr, landing in FETCH at addr.
   task automatic retarget(input logic [31:0] addr);
      fetch_to_exec(32'h0);
      jr = 1'b1;
      rs = addr;
      step();
      jr = 1'b0;
      rs = 32'h0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #2 reset = 1'b1;
      #1;
      total++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h want %h", pc, 32'h0); else passed++;
      total++; if (instr !== 32'h0) $display("FAIL reset_instr: got %h want %h", instr, 32'h0); else passed++;
      total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", instr_valid); else passed++;
      total++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req); else passed++;
      total++; if (fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", fault); else passed++;
      @(negedge clk);
      imem_ack   = 1'b1;
      imem_rdata = 32'hFFFF_0000;
      step();
      total++; if (instr !== 32'h0) $display("FAIL reset_ack_ignored: instr got %h want %h", instr, 32'h0); else passed++;
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      reset      = 1'b0;
      #1;
      total++; if ({imem_req, imem_addr} !== {1'b1, 32'h0})
         $display("FAIL release_fetch: req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, 32'h0); else passed++;
   endtask

   task automatic test_sequential();
      logic [31:0] exp_pc;
      for (int i = 0; i < 3; i++) begin
         exp_pc = 32'(i * 4);
         total++; if ({imem_req, instr_valid, imem_addr} !== {1'b1, 1'b0, exp_pc})
            $display("FAIL seq_fetch%0d: req=%b valid=%b addr=%h want 1 0 %h", i, imem_req, instr_valid, imem_addr, exp_pc); else passed++;
         fetch_to_exec(32'h0);
         total++; if ({imem_req, instr_valid, pc} !== {1'b0, 1'b1, exp_pc})
            $display("FAIL seq_exec%0d: req=%b valid=%b pc=%h want 0 1 %h", i, imem_req, instr_valid, pc, exp_pc); else passed++;
         step();
      end
      total++; if (imem_addr !== 32'hC) $display("FAIL seq_end: addr got %h want %h", imem_addr, 32'hC); else passed++;
   endtask

   task automatic test_branch();
      retarget(32'h100);
      total++; if (imem_addr !== 32'h100) $display("FAIL br_setup: addr got %h want %h", imem_addr, 32'h100); else passed++;
      fetch_to_exec(32'h0);
      total++; if (pc_add4 !== 32'h104) $display("FAIL br_add4: got %h want %h", pc_add4, 32'h104); else passed++;
      branch = 1'b1; zero = 1'b1; expand = 32'hFFFF_FFFE;
      step();
      branch = 1'b0; zero = 1'b0; expand = 32'h0;
      total++; if ({imem_req, imem_addr} !== {1'b1, 32'h0FC})
         $display("FAIL br_taken: req=%b addr=%h want 1 %h", imem_req, imem_addr, 32'h0FC); else passed++;
      retarget(32'h100);
      fetch_to_exec(32'h0);
      branch = 1'b1; zero = 1'b0; expand = 32'hFFFF_FFFE;
      step();
      branch = 1'b0; expand = 32'h0;
      total++; if (imem_addr !== 32'h104) $display("FAIL br_not_taken: addr got %h want %h", imem_addr, 32'h104); else passed++;
   endtask

   task automatic test_jump();
      retarget(32'h1000_0010);
      fetch_to_exec(32'h0000_0010);
      total++; if ({pc, instr} !== {32'h1000_0010, 32'h0000_0010})
         $display("FAIL jmp_setup: pc=%h instr=%h want %h %h", pc, instr, 32'h1000_0010, 32'h10); else passed++;
      jmp = 1'b1; jr = 1'b1; rs = 32'h40;
      step();
      jmp = 1'b0; jr = 1'b0; rs = 32'h0;
      total++; if (imem_addr !== 32'h40) $display("FAIL jr_over_jmp: addr got %h want %h", imem_addr, 32'h40); else passed++;
      retarget(32'h1000_0010);
      fetch_to_exec(32'h0000_0010);
      jmp = 1'b1; rs = 32'h40;
      step();
      jmp = 1'b0; rs = 32'h0;
      total++; if (imem_addr !== 32'h1000_0040) $display("FAIL jmp_only: addr got %h want %h", imem_addr, 32'h1000_0040); else passed++;
   endtask

   task automatic test_stall_wait();
      imem_ack = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (c == 1) begin
            stall = 1'b1; jr = 1'b1; rs = 32'h3;
         end
         if (c == 3) begin
            imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
         end
         total++; if ({imem_req, instr_valid, imem_addr} !== {1'b1, 1'b0, 32'h1000_0040})
            $display("FAIL wait_hold%0d: req=%b valid=%b addr=%h want 1 0 %h", c, imem_req, instr_valid, imem_addr, 32'h1000_0040); else passed++;
         step();
      end
      imem_rdata = 32'h1234_5678;
      for (int e = 0; e < 3; e++) begin
         if (e == 2) begin
            stall = 1'b0; jr = 1'b0; rs = 32'h0; imem_ack = 1'b0;
         end
         total++; if ({instr_valid, instr, pc, fault} !== {1'b1, 32'hDEAD_BEEF, 32'h1000_0040, 1'b0})
            $display("FAIL stall_hold%0d: valid=%b instr=%h pc=%h fault=%b want 1 %h %h 0", e, instr_valid, instr, pc, fault, 32'hDEAD_BEEF, 32'h1000_0040); else passed++;
         step();
      end
      imem_rdata = 32'h0;
      total++; if ({imem_req, imem_addr, fault} !== {1'b1, 32'h1000_0044, 1'b0})
         $display("FAIL stall_release: req=%b addr=%h fault=%b want 1 %h 0", imem_req, imem_addr, fault, 32'h1000_0044); else passed++;
   endtask

   task automatic test_wrap();
      retarget(32'hFFFF_FFFC);
      fetch_to_exec(32'h0);
      total++; if (pc_add4 !== 32'h0) $display("FAIL wrap_add4: got %h want %h", pc_add4, 32'h0); else passed++;
      step();
      total++; if (imem_addr !== 32'h0) $display("FAIL wrap_seq: addr got %h want %h", imem_addr, 32'h0); else passed++;
      fetch_to_exec(32'hA5A5_A5A5);
      step();
   endtask

   task automatic test_reset_mid_wait();
      imem_ack = 1'b0;
      step();
      total++; if ({imem_req, imem_addr, instr} !== {1'b1, 32'h4, 32'hA5A5_A5A5})
         $display("FAIL midwait_setup: req=%b addr=%h instr=%h want 1 %h %h", imem_req, imem_addr, instr, 32'h4, 32'hA5A5_A5A5); else passed++;
      #2 reset = 1'b1;
      imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
      #1;
      total++; if ({imem_req, instr, pc} !== {1'b0, 32'h0, 32'h0})
         $display("FAIL midwait_async: req=%b instr=%h pc=%h want 0 %h %h", imem_req, instr, pc, 32'h0, 32'h0); else passed++;
      step();
      total++; if ({instr, instr_valid} !== {32'h0, 1'b0})
         $display("FAIL midwait_ack_dropped: instr=%h valid=%b want %h 0", instr, instr_valid, 32'h0); else passed++;
      reset = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
      #1;
      total++; if ({imem_req, imem_addr} !== {1'b1, 32'h0})
         $display("FAIL midwait_refetch: req=%b addr=%h want 1 %h", imem_req, imem_addr, 32'h0); else passed++;
   endtask

   task automatic test_fault_halt();
      int bad;
      fetch_to_exec(32'h0);
      jr = 1'b1; rs = 32'h202;
      step();
      jr = 1'b0; rs = 32'h0;
      total++; if ({fault, pc, imem_req, instr_valid} !== {1'b1, 32'h0, 1'b0, 1'b0})
         $display("FAIL fault_enter: fault=%b pc=%h req=%b valid=%b want 1 %h 0 0", fault, pc, imem_req, instr_valid, 32'h0); else passed++;
      bad = 0;
      imem_ack = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (imem_req || instr_valid || !fault) bad++;
         step();
      end
      imem_ack = 1'b0;
      total++; if (bad !== 0) $display("FAIL halt_hold: bad cycles got %0d want 0", bad); else passed++;
      reset = 1'b1;
      #1;
      total++; if (fault !== 1'b0) $display("FAIL fault_clear: got %b want 0", fault); else passed++;
      step();
      reset = 1'b0;
      #1;
      total++; if ({imem_req, imem_addr} !== {1'b1, 32'h0})
         $display("FAIL halt_exit_fetch: req=%b addr=%h want 1 %h", imem_req, imem_addr, 32'h0); else passed++;
   endtask

   initial begin
      branch = 1'b0; zero = 1'b0; jmp = 1'b0; jr = 1'b0;
      expand = 32'h0; rs = 32'h0; stall = 1'b0;
      imem_ack = 1'b0; imem_rdata = 32'h0;
      test_reset();
      test_sequential();
      test_branch();
      test_jump();
      test_stall_wait();
      test_wrap();
      test_reset_mid_wait();
      test_fault_halt();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
